// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with fixed access latency
module dmem_responder #(
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_W;

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be in 1..15");
        end
    endgenerate

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [0:0]        state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] idx_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [31:0]       mem [DEPTH];

    logic done;
    logic misaligned;
    logic unused_addr_bits;

    assign done             = (state == WAIT) && (cnt == 4'd0);
    assign misaligned       = (off_q != 2'b00);
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= 32'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            off_q   <= 2'b00;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        idx_q   <= addr[ADDR_W+1:2];
                        off_q   <= addr[1:0];
                        wdata_q <= wdata;
                        be_q    <= be;
                        cnt     <= CNT_INIT;
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        ack   <= 1'b1;
                        busy  <= 1'b0;
                        err   <= misaligned;
                        state <= IDLE;
                        // Stores never touch rdata; misaligned loads return zero.
                        if (!we_q) begin
                            rdata <= misaligned ? 32'd0 : mem[idx_q];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM has no reset; a reset drops state to IDLE so no pending write can fire.
    always_ff @(posedge clk) begin
        if (done && we_q && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at LATENCY 2, 1 and 15
module tb_dmem_responder;

    logic        clk;
    logic        rst   [3];
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  be    [3];
    logic [31:0] rdata [3];
    logic        ack   [3];
    logic        err   [3];
    logic        busy  [3];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int cur_lat;
    int ack_cyc;
    int lat_of [3] = '{2, 1, 15};

    dmem_responder #(.ADDR_W(6), .LATENCY(2)) dut_l2 (
        .clk(clk), .reset(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .be(be[0]), .rdata(rdata[0]), .ack(ack[0]),
        .err(err[0]), .busy(busy[0]));

    dmem_responder #(.ADDR_W(6), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .be(be[1]), .rdata(rdata[1]), .ack(ack[1]),
        .err(err[1]), .busy(busy[1]));

    dmem_responder #(.ADDR_W(6), .LATENCY(15)) dut_l15 (
        .clk(clk), .reset(rst[2]), .req(req[2]), .we(we[2]), .addr(addr[2]),
        .wdata(wdata[2]), .be(be[2]), .rdata(rdata[2]), .ack(ack[2]),
        .err(err[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL L%0d %s: observed %h expected %h", cur_lat, tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, waits (bounded) for its ack and leaves the bench in the ack cycle.
    task automatic do_access(input int k, input bit w, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] b, input bit hold,
                             output logic [31:0] rd, output logic e);
        int  n;
        bit  got;
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = wd; be[k] = b;
        tick();
        if (!hold) req[k] = 1'b0;
        chk("busy_after_accept", 32'(busy[k]), 32'd1);
        n = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            tick();
            n++;
            if (ack[k]) got = 1'b1;
            else chk("busy_in_wait", 32'(busy[k]), 32'd1);
        end
        chk("ack_seen", 32'(got), 32'd1);
        chk("latency", 32'(n), 32'(cur_lat));
        chk("busy_in_ack", 32'(busy[k]), 32'd0);
        ack_cyc = cyc;
        req[k] = 1'b0;
        rd = rdata[k];
        e  = err[k];
    endtask

    task automatic run_all(input int k);
        logic [31:0] rd;
        logic        e;
        int          first_ack;
        int          extra;
        cur_lat = lat_of[k];

        chk("reset_ack", 32'(ack[k]), 32'd0);
        chk("reset_busy", 32'(busy[k]), 32'd0);
        chk("reset_err", 32'(err[k]), 32'd0);
        chk("reset_rdata", rdata[k], 32'd0);

        do_access(k, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, rd, e);
        chk("store_err", 32'(e), 32'd0);
        do_access(k, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, rd, e);
        chk("load_full", rd, 32'hDEADBEEF);
        chk("load_err", 32'(e), 32'd0);

        do_access(k, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0, rd, e);
        chk("store_keeps_rdata", rd, 32'hDEADBEEF);
        do_access(k, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, rd, e);
        chk("load_be_merge", rd, 32'hDE22BE44);

        do_access(k, 1'b0, 32'h13, 32'h0, 4'b1111, 1'b0, rd, e);
        chk("misaligned_load_err", 32'(e), 32'd1);
        chk("misaligned_load_rdata", rd, 32'd0);
        do_access(k, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, rd, e);
        chk("aligned_after_mis", rd, 32'hDE22BE44);
        chk("aligned_after_mis_err", 32'(e), 32'd0);

        do_access(k, 1'b1, 32'h12, 32'hFFFFFFFF, 4'b1111, 1'b0, rd, e);
        chk("misaligned_store_err", 32'(e), 32'd1);
        chk("misaligned_store_rdata", rd, 32'hDE22BE44);
        do_access(k, 1'b1, 32'h10, 32'h0BADF00D, 4'b0000, 1'b0, rd, e);
        chk("be0_store_err", 32'(e), 32'd0);
        do_access(k, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, rd, e);
        chk("no_write_effects", rd, 32'hDE22BE44);

        do_access(k, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b1, rd, e);
        chk("held_req_data", rd, 32'hDE22BE44);
        extra = 0;
        repeat (cur_lat + 3) begin
            tick();
            if (ack[k]) extra++;
        end
        chk("held_req_single_ack", 32'(extra), 32'd0);

        do_access(k, 1'b1, 32'h14, 32'hA5A5A5A5, 4'b1111, 1'b0, rd, e);
        first_ack = ack_cyc;
        do_access(k, 1'b0, 32'h14, 32'h0, 4'b1111, 1'b0, rd, e);
        chk("b2b_gap", 32'(ack_cyc - first_ack), 32'(cur_lat + 1));
        chk("b2b_hazard_data", rd, 32'hA5A5A5A5);

        do_access(k, 1'b1, 32'h20, 32'h01020304, 4'b1111, 1'b0, rd, e);
        req[k] = 1'b1; we[k] = 1'b1; addr[k] = 32'h20; wdata[k] = 32'hCAFEF00D; be[k] = 4'b1111;
        tick();
        req[k] = 1'b0;
        chk("pre_abort_busy", 32'(busy[k]), 32'd1);
        rst[k] = 1'b1;
        #1;
        chk("abort_busy", 32'(busy[k]), 32'd0);
        chk("abort_ack", 32'(ack[k]), 32'd0);
        chk("abort_rdata", rdata[k], 32'd0);
        tick();
        rst[k] = 1'b0;
        extra = 0;
        repeat (cur_lat + 2) begin
            tick();
            if (ack[k]) extra++;
        end
        chk("abort_no_ack", 32'(extra), 32'd0);
        do_access(k, 1'b0, 32'h20, 32'h0, 4'b1111, 1'b0, rd, e);
        chk("abort_no_write", rd, 32'h01020304);

        do_access(k, 1'b1, 32'h100, 32'h55AA55AA, 4'b1111, 1'b0, rd, e);
        do_access(k, 1'b0, 32'h000, 32'h0, 4'b1111, 1'b0, rd, e);
        chk("alias_load", rd, 32'h55AA55AA);
        tick();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0;
            addr[k] = 32'd0; wdata[k] = 32'd0; be[k] = 4'd0;
        end
        repeat (3) tick();
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) run_all(k);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the pipelined RISC-V core. It answers load/store requests issued by the core's MEM stage over a req/ack handshake, with a fixed multi-cycle access latency. It owns a word-organised RAM with byte-write enables. Its busy output drives the core's pipeline stall while an access is outstanding.

Parameters:
ADDR_W, 6, word-index width; RAM depth = 2**ADDR_W words of 32 bits
LATENCY, 2, cycles from request acceptance to ack; legal range 1..15

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
req  input  1  access request from the MEM stage
we  input  1  1 = store, 0 = load; sampled with req
addr  input  32  byte address; word index = addr[ADDR_W+1:2]
wdata  input  32  store data; sampled with req
be  input  4  byte enables; be[i] selects bits [8i+7:8i]
rdata  output  32  load data; valid in the ack cycle and held until the next load ack
ack  output  1  one-cycle completion pulse
err  output  1  misalignment flag; valid only while ack=1
busy  output  1  request outstanding; the core stalls on it

Behaviour:
- Reset, asynchronous, effective immediately:
  - state=IDLE; ack=0, err=0, busy=0, rdata=0; latency counter=0.
  - RAM contents are not cleared.
  - Any pending access is aborted and its write is never performed.
- FSM states:
  - IDLE: if req=1 at a rising edge t, latch we, addr, wdata and be; load counter with LATENCY-1; busy=1 from edge t; go to WAIT.
  - WAIT: req is ignored, so a held req does not re-trigger. Counter decrements each edge. At the edge where counter=0 (edge t+LATENCY):
    - perform the access;
    - ack=1 and busy=0 for exactly one cycle;
    - return to IDLE.
- Access rules:
  - Misaligned means latched addr[1:0] != 2'b00. Result: err=1 with ack, no RAM write, rdata=0 for a load, rdata unchanged for a store.
  - Store: RAM[idx] bytes with be[i]=1 are replaced by the matching wdata bytes; other bytes are kept; rdata unchanged.
  - Store with be=0000: no change, normal ack, err=0.
  - Load: rdata = full 32-bit RAM[idx]. be is ignored; byte/half extraction belongs to the core.
  - Address bits above ADDR_W+1 are ignored, so addresses alias modulo 2**(ADDR_W+2) bytes.
- Back-to-back: the ack cycle is an IDLE cycle.
  - A req seen at the edge ending the ack cycle (t+LATENCY+1) is accepted as a new request. Its ack follows at t+2*LATENCY+1.
  - The initiator must present its next request, or drop req, during the ack cycle.
- Hazards:
  - A load following a store to the same word returns the stored data.
  - No write-through to rdata on stores.
- Counter width: 4 bits.
- Synthesis check: LATENCY=0 is illegal and must be rejected (elaboration error).
- Single clock domain; all outputs are registered.

Test Plan:
- Basic store/load (LATENCY=2):
  - Reset, then store 0xDEADBEEF to 0x10 with be=1111, req accepted at edge t → busy=1 during t..t+2, ack pulse at t+2, err=0.
  - Then load 0x10 → rdata=0xDEADBEEF in its ack cycle.
- Byte enables: store 0x11223344 to 0x10 with be=0101 over 0xDEADBEEF → load 0x10 returns 0xDE22BE44.
- Misaligned load of 0x13 → ack with err=1, rdata=0. A following aligned load of 0x10 still returns 0xDE22BE44 with err=0.
- Handshake timing:
  - req held high through WAIT → exactly one ack.
  - A new load presented in the ack cycle (edge t+3) → accepted, second ack at edge t+5, no idle gap.
- Reset mid-operation: reset pulsed during WAIT of a store of 0xCAFEF00D to 0x20 → busy/ack drop to 0 asynchronously. A later load of 0x20 returns the pre-store value.
- Aliasing and latency range:
  - ADDR_W=6: store 0x55AA55AA to 0x100, then load 0x000 → 0x55AA55AA.
  - Repeat all scenarios at LATENCY=1 (ack at t+1) and LATENCY=15.
